// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble/redirect flush generation plus a context-switch drain FSM.
// Optional build macro HAZARD_WATCHDOG_EN adds a sticky stall watchdog on stall_o[0].
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES     = 4,
    parameter int REDIRECT_DEPTH = 2,
    parameter int RESUME_CYC     = 2,
    parameter int WDOG_LIMIT     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic                  redirect,
    input  logic                  ctx_req,
    input  logic                  ctx_keep_fetch,
    input  logic                  drain_pending,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  ctx_busy,
    output logic                  ctx_ack,
    output logic                  stall_timeout
);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, RESUME} state_e;

    localparam int CNT_W    = (RESUME_CYC > 1) ? $clog2(RESUME_CYC) : 1;
    localparam int CNT_LOAD = (RESUME_CYC > 0) ? RESUME_CYC - 1 : 0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] stall_prop;
    logic              drain_fl0, flush_all, hold_fetch;

    // An older stalled register holds every younger register behind it.
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_prop
        assign stall_prop[i] = |stall_req[NUM_STAGES-1:i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctx_ack    = 1'b0;
        drain_fl0  = 1'b0;
        flush_all  = 1'b0;
        hold_fetch = 1'b0;
        case (state_q)
            IDLE: if (ctx_req) state_d = DRAIN;
            DRAIN: begin
                drain_fl0 = ~ctx_keep_fetch;
                if (!drain_pending && stall_req == '0) state_d = FLUSH;
            end
            FLUSH: begin
                flush_all = 1'b1;
                ctx_ack   = 1'b1;
                if (RESUME_CYC > 0) begin
                    state_d = RESUME;
                    cnt_d   = CNT_W'(CNT_LOAD);
                end else begin
                    state_d = IDLE;
                end
            end
            RESUME: begin
                hold_fetch = 1'b1;
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bubbles are derived from the final hold vector, so a RESUME fetch hold
    // also drops a bubble into register 1.
    always_comb begin
        stall_o    = stall_prop;
        stall_o[0] = stall_prop[0] | hold_fetch;
        if (flush_all) stall_o = '0;
        flush_o = '0;
        for (int i = 1; i < NUM_STAGES; i++)
            flush_o[i] = stall_o[i-1] & ~stall_o[i];
        for (int i = 0; i < NUM_STAGES; i++)
            if (i < REDIRECT_DEPTH) flush_o[i] = flush_o[i] | redirect;
        flush_o[0] = flush_o[0] | drain_fl0;
        if (flush_all) flush_o = '1;
    end

    assign ctx_busy = (state_q != IDLE);

`ifdef HAZARD_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            tout_q;

    always_comb begin
        wd_d = wd_q;
        if (!stall_o[0])                     wd_d = '0;
        else if (wd_q != WD_W'(WDOG_LIMIT))  wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q   <= '0;
            tout_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (wd_d == WD_W'(WDOG_LIMIT)) tout_q <= 1'b1;
        end
    end

    assign stall_timeout = tout_q;
`else
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; a second instance covers the RESUME_CYC=0 build.
module tb_pipeline_hazard_ctrl;

    localparam int WL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] stall_req = '0;
    logic       redirect = 1'b0, ctx_req = 1'b0, ctx_req2 = 1'b0;
    logic       ctx_keep_fetch = 1'b0, drain_pending = 1'b0;
    logic [3:0] stall_o, flush_o, stall_o2, flush_o2;
    logic       ctx_busy, ctx_ack, stall_timeout;
    logic       ctx_busy2, ctx_ack2, stall_timeout2;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.NUM_STAGES(4), .REDIRECT_DEPTH(2), .RESUME_CYC(2), .WDOG_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .redirect(redirect), .ctx_req(ctx_req),
        .ctx_keep_fetch(ctx_keep_fetch), .drain_pending(drain_pending),
        .stall_o(stall_o), .flush_o(flush_o), .ctx_busy(ctx_busy), .ctx_ack(ctx_ack),
        .stall_timeout(stall_timeout));

    pipeline_hazard_ctrl #(.NUM_STAGES(4), .REDIRECT_DEPTH(2), .RESUME_CYC(0), .WDOG_LIMIT(WL)) dut2 (
        .clk(clk), .rst(rst), .stall_req(stall_req), .redirect(redirect), .ctx_req(ctx_req2),
        .ctx_keep_fetch(ctx_keep_fetch), .drain_pending(drain_pending),
        .stall_o(stall_o2), .flush_o(flush_o2), .ctx_busy(ctx_busy2), .ctx_ack(ctx_ack2),
        .stall_timeout(stall_timeout2));

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] fl;
        logic       busy;
        logic       ack;
        logic       tout;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;
    int   wd_cnt = 0;
    logic wd_tout = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_head(input string tag, input bit which);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        if (!which) begin
            check({tag, ".stall"}, 32'(stall_o), 32'(e.st));
            check({tag, ".flush"}, 32'(flush_o), 32'(e.fl));
            check({tag, ".busy"},  32'(ctx_busy), 32'(e.busy));
            check({tag, ".ack"},   32'(ctx_ack), 32'(e.ack));
            check({tag, ".tout"},  32'(stall_timeout), 32'(e.tout));
        end else begin
            check({tag, ".stall2"}, 32'(stall_o2), 32'(e.st));
            check({tag, ".flush2"}, 32'(flush_o2), 32'(e.fl));
            check({tag, ".busy2"},  32'(ctx_busy2), 32'(e.busy));
            check({tag, ".ack2"},   32'(ctx_ack2), 32'(e.ack));
        end
    endtask

    task automatic wd_reset();
        wd_cnt  = 0;
        wd_tout = 1'b0;
    endtask

    // One clock cycle: drive at posedge+1, expect at negedge, then advance.
    task automatic cyc(input string tag, input bit which, input logic [3:0] sr, input logic rd,
                       input logic cr, input logic kf, input logic dp,
                       input logic [3:0] est, input logic [3:0] efl, input logic eb, input logic ea);
        logic s0;
        stall_req = sr; redirect = rd; ctx_keep_fetch = kf; drain_pending = dp;
        ctx_req  = which ? 1'b0 : cr;
        ctx_req2 = which ? cr : 1'b0;
        sb.push_back('{est, efl, eb, ea, wd_tout});
        @(negedge clk);
        compare_head(tag, which);
        s0 = which ? (sr != 4'b0) : est[0];
`ifdef HAZARD_WATCHDOG_EN
        if (!s0) wd_cnt = 0;
        else if (wd_cnt < WL) wd_cnt++;
        if (wd_cnt == WL) wd_tout = 1'b1;
`else
        if (s0) wd_cnt = 0;
`endif
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] comb_model(input logic [3:0] sr, input logic rd);
        logic [3:0] s, f;
        logic acc;
        acc = 1'b0;
        f = '0;
        for (int i = 3; i >= 0; i--) begin
            acc  = acc | sr[i];
            s[i] = acc;
        end
        for (int i = 1; i < 4; i++) f[i] = s[i-1] & ~s[i];
        if (rd) f = f | 4'b0011;
        return {s, f};
    endfunction

    initial begin
        logic [3:0] sr;
        logic       rd;
        logic [7:0] m;

        // reset state: combinational paths still live, FSM outputs quiet
        #1;
        stall_req = 4'b0100;
        sb.push_back('{4'b0111, 4'b1000, 1'b0, 1'b0, 1'b0});
        #1 compare_head("rst_hold", 1'b0);
        stall_req = 4'b0000;
        sb.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
        #1 compare_head("rst_idle", 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;

        cyc("ex_hold",   0, 4'b0100, 0, 0, 0, 0, 4'b0111, 4'b1000, 0, 0);
        cyc("wb_hold",   0, 4'b1000, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0);
        cyc("redir",     0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0011, 0, 0);
        cyc("redir_if",  0, 4'b0001, 1, 0, 0, 0, 4'b0001, 4'b0011, 0, 0);
        cyc("id_hold",   0, 4'b0010, 0, 0, 0, 0, 4'b0011, 4'b0100, 0, 0);
        cyc("quiet",     0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);

        for (int k = 0; k < 16; k++) begin
            sr = 4'($urandom_range(0, 15));
            rd = 1'($urandom_range(0, 1));
            m  = comb_model(sr, rd);
            cyc("rand", 0, sr, rd, 0, 0, 0, m[7:4], m[3:0], 0, 0);
        end
        cyc("quiet2", 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // context switch, drain_pending for three cycles
        cyc("sw_req",    0, 4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0);
        cyc("sw_drain1", 0, 4'b0000, 0, 0, 0, 1, 4'b0000, 4'b0001, 1, 0);
        cyc("sw_drain2", 0, 4'b0000, 0, 0, 0, 1, 4'b0000, 4'b0001, 1, 0);
        cyc("sw_drain3", 0, 4'b0000, 0, 0, 0, 1, 4'b0000, 4'b0001, 1, 0);
        cyc("sw_drain4", 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0001, 1, 0);
        cyc("sw_flush",  0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1111, 1, 1);
        cyc("sw_res1",   0, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b0010, 1, 0);
        cyc("sw_res2",   0, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b0010, 1, 0);
        cyc("sw_idle",   0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // keep-fetch, stall_req holding DRAIN, redirect in FLUSH and RESUME
        cyc("kf_req",    0, 4'b0000, 0, 1, 1, 0, 4'b0000, 4'b0000, 0, 0);
        cyc("kf_drain1", 0, 4'b0000, 0, 0, 1, 1, 4'b0000, 4'b0000, 1, 0);
        cyc("kf_drain2", 0, 4'b0100, 0, 0, 1, 0, 4'b0111, 4'b1000, 1, 0);
        cyc("kf_drain3", 0, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0000, 1, 0);
        cyc("kf_flush",  0, 4'b0100, 1, 0, 0, 0, 4'b0000, 4'b1111, 1, 1);
        cyc("kf_res1",   0, 4'b0000, 1, 0, 0, 0, 4'b0001, 4'b0011, 1, 0);
        cyc("kf_res2",   0, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b0010, 1, 0);
        cyc("kf_idle",   0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // RESUME_CYC=0 instance: FLUSH returns straight to IDLE
        cyc("z_req",     1, 4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0);
        cyc("z_drain",   1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0001, 1, 0);
        cyc("z_flush",   1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1111, 1, 1);
        cyc("z_idle",    1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // asynchronous reset in the middle of RESUME
        cyc("r_req",     0, 4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0);
        cyc("r_drain",   0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0001, 1, 0);
        cyc("r_flush",   0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1111, 1, 1);
        sb.push_back('{4'b0001, 4'b0010, 1'b1, 1'b0, wd_tout});
        #1 compare_head("r_resume", 1'b0);
        rst = 1'b1;
        wd_reset();
        sb.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
        #1 compare_head("r_async", 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        cyc("r_after",   0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // watchdog: one short of the limit, then exactly the limit
        for (int k = 0; k < WL - 1; k++)
            cyc("wd_short", 0, 4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0010, 0, 0);
        cyc("wd_rel1",   0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
        cyc("wd_rel2",   0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < WL; k++)
            cyc("wd_full", 0, 4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0010, 0, 0);
        cyc("wd_after1", 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
        cyc("wd_after2", 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised pipeline hazard controller for the RV32IM multithreaded core: turns per-stage stall requests, control-flow redirects and context-switch requests into per-pipeline-register stall and flush enables. It generalises the fixed IF/ID/EX/MEM stall/flush logic to NUM_STAGES registers and adds a sequenced context-switch drain FSM with a hold-off counter. It sits beside the pipeline registers and drives their hold and bubble inputs.

## Interface
- NUM_STAGES, 4, number of controlled pipeline registers; index 0 = IF/ID register, NUM_STAGES-1 = last (MEM/WB).
- REDIRECT_DEPTH, 2, number of youngest registers (0..REDIRECT_DEPTH-1) flushed on a redirect; 1..NUM_STAGES.
- RESUME_CYC, 2, cycles fetch is held after a context-switch flush; 0 allowed.
- WDOG_LIMIT, 1024, consecutive stall_o[0] cycles before timeout (watchdog build only); ≥1.
- One clock; reset is asynchronous and active-high.
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- stall_req  in  NUM_STAGES  bit k: register k cannot advance (forward hazard, div/rem busy, L2 data wait, ...).
- redirect  in  1  branch/jump/finish_function/finish_thread redirect this cycle.
- ctx_req  in  1  context-switch request, level; held until ctx_ack.
- ctx_keep_fetch  in  1  core-control instruction in flight; suppresses fetch flush during DRAIN.
- drain_pending  in  1  older instructions still outstanding (memory/L2 ops).
- stall_o  out  NUM_STAGES  hold enable per register.
- flush_o  out  NUM_STAGES  bubble enable per register; consumer gives flush priority over stall.
- ctx_busy  out  1  FSM not IDLE.
- ctx_ack  out  1  one-cycle pulse, asserted in FLUSH state.
- stall_timeout  out  1  sticky watchdog flag.

## Operation
- Stall propagation: stall_o[i] = OR of stall_req[j] for j ≥ i (older stall holds all younger registers).
- Bubble insertion: flush_o[i] asserted when stall_req[i-1]... precisely, when stall_o[i-1]=1 and stall_o[i]=0 (i ≥ 1); register i receives a bubble behind the stalled register.
- Redirect: flush_o[0..REDIRECT_DEPTH-1] asserted in the cycle redirect=1, regardless of FSM state.
- FSM states IDLE, DRAIN, FLUSH, RESUME; all outputs below OR with the rules above.
- IDLE: ctx_req=1 → DRAIN.
- DRAIN: flush_o[0]=1 unless ctx_keep_fetch=1; stays while drain_pending=1 or stall_req≠0; else → FLUSH.
- FLUSH: exactly one cycle; flush_o all ones, stall_o forced to zero; ctx_ack=1; → RESUME if RESUME_CYC>0, else IDLE.
- RESUME: stall_o[0]=1; counter loads RESUME_CYC-1 on entry, decrements; at 0 → IDLE.
- ctx_req in any non-IDLE state ignored; requester must drop ctx_req the cycle after ctx_ack, else a new switch starts.
- ctx_busy = (state ≠ IDLE).

## Timing
- stall_o/flush_o from stall_req and redirect: combinational, zero latency.
- ctx_req sampled at edge t in IDLE → DRAIN visible t+1; minimum switch: DRAIN 1 cycle, FLUSH 1, RESUME RESUME_CYC, then IDLE.
- Reset (any time, incl. mid-switch): state IDLE, counters 0, stall_timeout 0; outputs then reflect only stall_req/redirect (ctx_busy=0, ctx_ack=0).
- Redirect during DRAIN/RESUME: flushes applied, FSM progression unchanged.
- Redirect coincident with FLUSH: no change (all already flushed).

## Configuration
- HAZARD_WATCHDOG_EN defined: counter of width $clog2(WDOG_LIMIT+1) increments each cycle stall_o[0]=1, clears when 0, saturates at WDOG_LIMIT; reaching WDOG_LIMIT sets stall_timeout, held until rst.
- Undefined: no counter; stall_timeout tied 0.

## Test plan
- Defaults, stall_req=4'b0100 (EX hold) → stall_o=4'b0111, flush_o=4'b1000; stall_req=4'b1000 → stall_o=4'b1111, flush_o=0.
- redirect=1 with stall_req=0 → flush_o=4'b0011, stall_o=0; with stall_req=4'b0001 → stall_o=4'b0001, flush_o=4'b0011.
- ctx_req at t, drain_pending high t+1..t+3 → DRAIN t+1..t+4 with flush_o[0]=1, FLUSH t+5 (flush_o=4'b1111, ctx_ack=1), RESUME t+6..t+7 stall_o[0]=1, IDLE t+8.
- Same as above with ctx_keep_fetch=1 → flush_o[0]=0 during DRAIN; RESUME_CYC=0 build → IDLE directly after FLUSH.
- rst pulse in RESUME → ctx_busy=0 immediately (async), stall_o=0 next cycle with no inputs.
- HAZARD_WATCHDOG_EN, WDOG_LIMIT=8, stall_req[0] held 8 cycles → stall_timeout=1 after 8th cycle, stays 1 after stall drops; 7 cycles then release → stays 0.
